// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bus bundle between the fetch stage and its neighbours
// (instruction cache, branch predictor, instruction queue, commit redirect).
//   icache_req_*   : one-cycle fetch request pulse + address (fetch -> cache)
//   icache_rsp_*   : returned instruction word (cache -> fetch)
//   pred_addr      : predictor index of the in-flight fetch (fetch -> predictor)
//   pred_taken     : predictor direction for pred_addr (predictor -> fetch)
//   iq_full        : queue back-pressure (queue -> fetch)
//   iq_*           : one-cycle push of a decoded entry (fetch -> queue)
//   redirect_*     : mispredict flush with the correct PC (commit -> fetch)
// master = fetch unit side, slave = environment side.
interface fetch_unit_if #(
  parameter int LOCAL_WIDTH = 10
);
  logic                   icache_req_valid;
  logic [31:0]            icache_req_addr;
  logic                   icache_rsp_valid;
  logic [31:0]            icache_rsp_instr;
  logic [LOCAL_WIDTH-1:0] pred_addr;
  logic                   pred_taken;
  logic                   iq_full;
  logic                   iq_valid;
  logic [31:0]            iq_instr;
  logic [31:0]            iq_pc;
  logic                   iq_pred_taken;
  logic [31:0]            iq_next_pc;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;

  modport master (
    output icache_req_valid, icache_req_addr, pred_addr,
           iq_valid, iq_instr, iq_pc, iq_pred_taken, iq_next_pc,
    input  icache_rsp_valid, icache_rsp_instr, pred_taken, iq_full,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  icache_req_valid, icache_req_addr, pred_addr,
           iq_valid, iq_instr, iq_pc, iq_pred_taken, iq_next_pc,
    output icache_rsp_valid, icache_rsp_instr, pred_taken, iq_full,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Keeps the PC, issues one icache
// request at a time, pre-decodes JAL / conditional branches in the returned
// word, consults the predictor and pushes {instr, pc, taken, next_pc} to the
// instruction queue. Commit redirects override everything.
// Ports:
//   clk_in  : clock
//   rst_in  : asynchronous active-low reset
//   rdy_in  : global stall; while low nothing changes and inputs are ignored
//   bus     : fetch_unit_if.master (cache, predictor, queue, redirect)
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          LOCAL_WIDTH = 10
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] next_pc;
  } iq_entry_t;

  localparam iq_entry_t ENTRY_ZERO = '0;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  iq_entry_t   hold_q, hold_d;
  iq_entry_t   iq_q, iq_d;
  logic        iq_valid_q, iq_valid_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_addr_q, req_addr_d;

  logic      rsp, full, redir;
  iq_entry_t dec;
  logic [31:0] imm_j, imm_b;
  logic [6:0]  opcode;
  logic [31:0] ins;

  assign rsp   = bus.icache_rsp_valid;
  assign full  = bus.iq_full;
  assign redir = bus.redirect_valid;
  assign ins   = bus.icache_rsp_instr;

  // pc_q only moves past the in-flight fetch when its response is consumed,
  // so the index stays stable for the whole WAIT window.
  assign bus.pred_addr = pc_q[LOCAL_WIDTH+1:2];

  // pre-decode of the returned word against the PC of the in-flight fetch
  assign opcode = ins[6:0];
  assign imm_j  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  assign imm_b  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};

  always_comb begin
    dec         = ENTRY_ZERO;
    dec.instr   = ins;
    dec.pc      = pc_q;
    dec.taken   = 1'b0;
    dec.next_pc = pc_q + 32'd4;
    if (opcode == 7'b1101111) begin
      dec.taken   = 1'b1;
      dec.next_pc = pc_q + imm_j;
    end else if (opcode == 7'b1100011) begin
      dec.taken   = bus.pred_taken;
      dec.next_pc = bus.pred_taken ? pc_q + imm_b : pc_q + 32'd4;
    end
  end

  // state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     state_q <= IDLE;
    else if (rdy_in) state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    if (redir) begin
      // A redirect with the response already here needs no drain; this also
      // covers DRAIN, otherwise the consumed response would never come back.
      unique case (state_q)
        WAIT, DRAIN: state_d = rsp ? IDLE : DRAIN;
        default:     state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE:    if (!full) state_d = WAIT;
        WAIT:    if (rsp)   state_d = full ? HOLD : IDLE;
        HOLD:    if (!full) state_d = IDLE;
        DRAIN:   if (rsp)   state_d = IDLE;
        default:            state_d = IDLE;
      endcase
    end
  end

  // next values of the registered outputs, PC and hold buffer
  always_comb begin
    pc_d        = pc_q;
    hold_d      = hold_q;
    iq_d        = iq_q;
    iq_valid_d  = 1'b0;
    req_valid_d = 1'b0;
    req_addr_d  = req_addr_q;
    if (redir) begin
      pc_d   = bus.redirect_pc;
      hold_d = ENTRY_ZERO;
    end else begin
      unique case (state_q)
        IDLE: if (!full) begin
          req_valid_d = 1'b1;
          req_addr_d  = pc_q;
        end
        WAIT: if (rsp) begin
          pc_d = dec.next_pc;
          if (!full) begin
            iq_valid_d = 1'b1;
            iq_d       = dec;
          end else begin
            hold_d = dec;
          end
        end
        HOLD: if (!full) begin
          iq_valid_d = 1'b1;
          iq_d       = hold_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pc_q        <= RESET_PC;
      hold_q      <= ENTRY_ZERO;
      iq_q        <= ENTRY_ZERO;
      iq_valid_q  <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= 32'h0;
    end else if (rdy_in) begin
      pc_q        <= pc_d;
      hold_q      <= hold_d;
      iq_q        <= iq_d;
      iq_valid_q  <= iq_valid_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
    end
  end

  assign bus.icache_req_valid = req_valid_q;
  assign bus.icache_req_addr  = req_addr_q;
  assign bus.iq_valid         = iq_valid_q;
  assign bus.iq_instr         = iq_q.instr;
  assign bus.iq_pc            = iq_q.pc;
  assign bus.iq_pred_taken    = iq_q.taken;
  assign bus.iq_next_pc       = iq_q.next_pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;

  fetch_unit_if #(.LOCAL_WIDTH(10)) bus();
  fetch_unit #(.RESET_PC(32'h0), .LOCAL_WIDTH(10)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] nxt;
  } ent_t;

  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] JAL  = 32'h0100_006F;
  localparam logic [31:0] BEQ  = 32'hFE00_0EE3;

  ent_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] cur_pc = 32'h0;
  bit          after_rsp = 0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic ent_t model(logic [31:0] i, logic [31:0] pc, logic pt);
    ent_t e;
    logic [31:0] imm;
    e.instr = i; e.pc = pc; e.tk = 1'b0; e.nxt = pc + 32'd4;
    if (i[6:0] == 7'b1101111) begin
      imm   = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      e.tk  = 1'b1;
      e.nxt = pc + imm;
    end else if (i[6:0] == 7'b1100011) begin
      imm  = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      e.tk = pt;
      if (pt) e.nxt = pc + imm;
    end
    return e;
  endfunction

  // queue-side monitor: every push must match the oldest expected entry
  initial forever begin
    @(negedge clk_in);
    if (bus.iq_valid === 1'b1) begin
      if (sb.size() == 0) chk("iq_unexpected", 32'd1, 32'd0);
      else begin
        ent_t e;
        e = sb.pop_front();
        chk("iq_instr", bus.iq_instr, e.instr);
        chk("iq_pc", bus.iq_pc, e.pc);
        chk("iq_taken", {31'b0, bus.iq_pred_taken}, {31'b0, e.tk});
        chk("iq_next_pc", bus.iq_next_pc, e.nxt);
      end
    end
  end

  task automatic wait_req(output logic [31:0] a, output int lat);
    lat = 0;
    a   = 32'hx;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      lat++;
      if (bus.icache_req_valid === 1'b1) begin
        a = bus.icache_req_addr;
        return;
      end
    end
    chk("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_req(logic [31:0] exp);
    logic [31:0] a;
    int lat;
    wait_req(a, lat);
    chk("req_addr", a, exp);
    if (after_rsp) chk("req_lat", lat, 2);
    after_rsp = 0;
  endtask

  task automatic respond(int dly, logic [31:0] instr, logic pt, bit accept);
    repeat (dly) @(negedge clk_in);
    chk("req_pulse", {31'b0, bus.icache_req_valid}, 32'd0);
    bus.icache_rsp_instr = instr;
    bus.pred_taken       = pt;
    bus.icache_rsp_valid = 1'b1;
    if (accept) begin
      ent_t e;
      e = model(instr, cur_pc, pt);
      sb.push_back(e);
      cur_pc    = e.nxt;
      after_rsp = !bus.iq_full;
    end
    @(posedge clk_in); #1;
    bus.icache_rsp_valid = 1'b0;
    bus.pred_taken       = 1'b0;
  endtask

  task automatic fetch(logic [31:0] instr, logic pt);
    expect_req(cur_pc);
    chk("pred_addr", {22'b0, bus.pred_addr}, {22'b0, cur_pc[11:2]});
    respond(1, instr, pt, 1);
  endtask

  task automatic redirect(logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    @(posedge clk_in); #1;
    bus.redirect_valid = 1'b0;
    cur_pc = pc;
  endtask

  task automatic chk_outs_zero(string tag);
    chk({tag, "_req_valid"}, {31'b0, bus.icache_req_valid}, 32'd0);
    chk({tag, "_req_addr"}, bus.icache_req_addr, 32'd0);
    chk({tag, "_iq_valid"}, {31'b0, bus.iq_valid}, 32'd0);
    chk({tag, "_iq_instr"}, bus.iq_instr, 32'd0);
    chk({tag, "_iq_pc"}, bus.iq_pc, 32'd0);
    chk({tag, "_iq_taken"}, {31'b0, bus.iq_pred_taken}, 32'd0);
    chk({tag, "_iq_next_pc"}, bus.iq_next_pc, 32'd0);
    chk({tag, "_pred_addr"}, {22'b0, bus.pred_addr}, 32'd0);
  endtask

  initial begin
    bus.icache_rsp_valid = 1'b0;
    bus.icache_rsp_instr = 32'h0;
    bus.pred_taken       = 1'b0;
    bus.iq_full          = 1'b0;
    bus.redirect_valid   = 1'b0;
    bus.redirect_pc      = 32'h0;

    repeat (2) @(negedge clk_in);
    chk_outs_zero("rst");
    rst_in = 1'b1;

    // straight-line fetches: ADDI, ADDI, JAL (+16)
    fetch(ADDI, 1'b0);
    fetch(ADDI, 1'b0);
    fetch(JAL, 1'b0);

    // redirect in WAIT with no response: drain the late word, refetch 0x10
    expect_req(32'h18);
    redirect(32'h10);
    @(negedge clk_in);
    chk("redir_no_push", {31'b0, bus.iq_valid}, 32'd0);
    respond(0, ADDI, 1'b0, 0);

    // BEQ -4 predicted taken at 0x10
    fetch(BEQ, 1'b1);

    // redirect and response in the same WAIT cycle: response discarded
    expect_req(32'hC);
    @(negedge clk_in);
    bus.icache_rsp_instr = JAL;
    bus.icache_rsp_valid = 1'b1;
    redirect(32'h10);
    bus.icache_rsp_valid = 1'b0;

    // BEQ predicted not taken at 0x10
    fetch(BEQ, 1'b0);

    // queue full at response time: entry held, pushed once space frees
    expect_req(32'h14);
    bus.iq_full = 1'b1;
    respond(1, ADDI, 1'b0, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      chk("hold_no_push", {31'b0, bus.iq_valid}, 32'd0);
      chk("hold_no_req", {31'b0, bus.icache_req_valid}, 32'd0);
    end
    bus.iq_full = 1'b0;
    expect_req(32'h18);

    // redirect to 0x100 in WAIT, response two cycles later is dropped
    redirect(32'h100);
    @(negedge clk_in);
    chk("redir2_no_push", {31'b0, bus.iq_valid}, 32'd0);
    respond(1, JAL, 1'b1, 0);
    expect_req(32'h100);

    // stall for 4 cycles with a response pulse inside: nothing moves
    rdy_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.icache_rsp_instr = JAL;
      bus.icache_rsp_valid = (k == 1);
      @(negedge clk_in);
      chk("frz_req_valid", {31'b0, bus.icache_req_valid}, 32'd1);
      chk("frz_req_addr", bus.icache_req_addr, 32'h100);
      chk("frz_iq_valid", {31'b0, bus.iq_valid}, 32'd0);
      chk("frz_pred_addr", {22'b0, bus.pred_addr}, 32'h40);
    end
    bus.icache_rsp_valid = 1'b0;
    rdy_in = 1'b1;
    respond(1, ADDI, 1'b0, 1);
    expect_req(32'h104);

    // asynchronous reset mid-WAIT
    #2 rst_in = 1'b0;
    #1 chk_outs_zero("arst");
    bus.iq_full = 1'b1;
    @(negedge clk_in);
    rst_in    = 1'b1;
    cur_pc    = 32'h0;
    after_rsp = 0;
    // stray response in IDLE (queue full keeps it there) must be ignored
    respond(1, JAL, 1'b1, 0);
    @(negedge clk_in);
    chk("idle_rsp_no_push", {31'b0, bus.iq_valid}, 32'd0);
    chk("idle_full_no_req", {31'b0, bus.icache_req_valid}, 32'd0);
    bus.iq_full = 1'b0;
    fetch(ADDI, 1'b0);
    expect_req(32'h4);

    repeat (3) @(negedge clk_in);
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly upstream of the branch predictor and the instruction queue. Holds the PC and issues one instruction-cache request at a time. Pre-decodes each returned word for JAL and conditional branches, queries the predictor with the low PC bits, and computes the next fetch PC. Pushes {instruction, PC, predicted direction, predicted next PC} to the instruction queue, and accepts redirects from commit on misprediction.

## Interface
Parameters:
- RESET_PC, 32'h0, PC loaded on reset
- LOCAL_WIDTH, 10, predictor index width; index = pc[LOCAL_WIDTH+1:2]

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset; one clock; reset is asynchronous and active-low
- rdy_in  in  1  pause when low; no register changes
- icache_req_valid  out  1  registered, one-cycle request pulse
- icache_req_addr  out  32  fetch address, valid with req pulse
- icache_rsp_valid  in  1  instruction word valid
- icache_rsp_instr  in  32  fetched word
- pred_addr  out  LOCAL_WIDTH  combinational; pc[LOCAL_WIDTH+1:2] of in-flight fetch
- pred_taken  in  1  predictor output for pred_addr
- iq_full  in  1  queue cannot accept a push this cycle
- iq_valid  out  1  registered, one-cycle push pulse
- iq_instr  out  32  pushed instruction
- iq_pc  out  32  its PC
- iq_pred_taken  out  1  1 if fetch followed a taken path
- iq_next_pc  out  32  PC fetched after it
- redirect_valid  in  1  mispredict/flush from commit
- redirect_pc  in  32  correct PC

## Operation
- States: IDLE, WAIT (request outstanding), HOLD (decoded entry waiting for queue space), DRAIN (redirected while request outstanding; discard response).
- IDLE: if !iq_full and !redirect_valid → req_valid<=1, req_addr<=pc, WAIT. Otherwise stay.
- WAIT: req_valid<=0. On rsp_valid, decode opcode = instr[6:0]:
  - 1101111 (JAL): taken=1, next=pc+immJ, immJ={{12{i[31]}},i[19:12],i[20],i[30:21],1'b0}.
  - 1100011 (branch): taken=pred_taken, next = taken ? pc+immB : pc+4, immB={{20{i[31]}},i[7],i[30:25],i[11:8],1'b0}.
  - Otherwise, including JALR: taken=0, next=pc+4.
  - Adds are 32-bit, wrap modulo 2^32.
  - If !iq_full: push (iq_* registered, iq_valid<=1), pc<=next, IDLE. Else latch the entry into the hold buffer, pc<=next, HOLD.
- HOLD: when !iq_full, push the held entry, IDLE.
- redirect_valid (any state, highest priority):
  - pc<=redirect_pc, iq_valid<=0, hold buffer dropped.
  - From WAIT with no rsp_valid in the same cycle → DRAIN. Otherwise → IDLE; a same-cycle response is discarded.
- DRAIN: on rsp_valid discard the word, → IDLE. A redirect in DRAIN updates pc and stays in DRAIN.
- rdy_in low: all state, pc and outputs frozen; inputs (including redirect) ignored.
- Reset values: state IDLE, pc=RESET_PC, icache_req_valid=0, icache_req_addr=0, iq_valid=0, iq_instr=0, iq_pc=0, iq_pred_taken=0, iq_next_pc=0. Reset mid-fetch abandons the request; any later response arriving in IDLE is ignored.

## Timing
- Request: IDLE at cycle t → req_valid high during t+1 only.
- rsp_valid is accepted at cycle t+2 at the earliest.
- pred_taken is sampled in the same cycle as rsp_valid. pred_addr must be stable from t+1 until the response.
- Response at cycle r with !iq_full → iq_valid high during r+1 only; next req_valid at r+2.
- Peak rate: one instruction per 3 cycles with a 1-cycle cache.
- HOLD: push occurs the cycle after iq_full is first sampled low.
- Redirect at cycle d: new PC is requested no earlier than d+2 (IDLE at d+1). No iq_valid at d+1.
- rsp_valid outside WAIT/DRAIN is ignored.

## Test plan
- Reset, RESET_PC=0x0, cache returns 32'h00000013 (ADDI) → iq_valid with iq_pc=0x0, iq_next_pc=0x4, iq_pred_taken=0; next request addr 0x4.
- JAL 32'h0100006F at PC 0x8 → iq_pred_taken=1, iq_next_pc=0x18; next req_addr=0x18.
- BEQ 32'hFE000EE3 (offset −4) at PC 0x10: pred_taken=1 → next 0xC; repeat with pred_taken=0 → next 0x14. Check pred_addr=0x4 during WAIT.
- iq_full high when response arrives → no iq_valid. Release iq_full after 3 cycles → single push with correct fields, then a new request.
- Redirect to 0x100 while WAIT; response arrives 2 cycles later → response discarded, no iq_valid; next req_addr=0x100.
- rdy_in low for 4 cycles mid-WAIT with rsp_valid pulsed → state and outputs unchanged. Assert rst_in low mid-WAIT → all outputs 0 immediately, pc=RESET_PC.
